// File: rtl/synth_ctrl_pkg.sv
// Shared types and constants for the synth control sequencer: command
// encoding, FSM state codes and keypad code helpers.
package synth_ctrl_pkg;

  typedef enum logic [1:0] {
    CMD_INSTR = 2'd0,
    CMD_DELAY = 2'd1,
    CMD_ATT   = 2'd2,
    CMD_SWAP  = 2'd3
  } cmd_e;

  // One queued command: opcode plus the raw key code (instrument number
  // for CMD_INSTR, don't-care for the others).
  typedef struct packed {
    cmd_e       op;
    logic [3:0] payload;
  } cmd_t;

  // FSM state encoding
  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_ISSUE    = 3'd1;
  localparam logic [2:0] ST_FADE_OUT = 3'd2;
  localparam logic [2:0] ST_SWAP     = 3'd3;
  localparam logic [2:0] ST_FADE_IN  = 3'd4;

  // Keypad codes with a special meaning
  localparam logic [3:0] KEY_A = 4'hA;
  localparam logic [3:0] KEY_B = 4'hB;
  localparam logic [3:0] KEY_F = 4'hF;

  // True for codes that map to a command (1-9, A, B, F); 0, C, D, E are ignored.
  function automatic logic key_is_cmd(input logic [3:0] code);
    return ((code >= 4'd1) && (code <= 4'd9)) ||
           (code == KEY_A) || (code == KEY_B) || (code == KEY_F);
  endfunction

  // Translate a mapped key code into a command word.
  function automatic cmd_t key_to_cmd(input logic [3:0] code);
    cmd_t c;
    c.payload = code;
    case (code)
      KEY_A:   c.op = CMD_DELAY;
      KEY_B:   c.op = CMD_ATT;
      KEY_F:   c.op = CMD_SWAP;
      default: c.op = CMD_INSTR;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/cmd_fifo.sv
// Small synchronous FIFO for queued keypad commands. A push while full is
// accepted only when a pop happens in the same cycle (count then unchanged).
module cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 6
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push,
  input  logic [WIDTH-1:0]             wdata,
  input  logic                         pop,
  output logic [WIDTH-1:0]             rdata,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  // Storage array; contents need no reset because count gates visibility.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // Pointers and occupancy; DEPTH is a power of two so pointers wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/synth_ctrl_sequencer.sv
// Control sequencer between keypad decode and the audio datapath. Keypad
// commands are queued and issued at most one per audio sample tick; a swap
// command fades gain to zero, flips headphone routing and fades back up.
//
// Handshake: key_valid is a one-cycle strobe with no back-pressure; a mapped
// command arriving while the queue is full (and nothing pops that cycle) is
// dropped and flagged on the sticky overflow bit.
//
// Issue timing: the head is popped on the sample_tick cycle in IDLE, the
// following cycle is ISSUE, and the registered pulse (together with the new
// instrument value) is visible in the cycle after ISSUE.
module synth_ctrl_sequencer
  import synth_ctrl_pkg::*;
#(
  parameter int CMD_DEPTH = 4,
  parameter int GAIN_W    = 4,
  parameter int FADE_DIV  = 1
) (
  input  logic              clk_100,
  input  logic              reset_n,
  input  logic              key_valid,
  input  logic [3:0]        key_code,
  input  logic              sample_tick,
  output logic [3:0]        instruments,
  output logic              new_instrument,
  output logic              next_delay,
  output logic              next_att,
  output logic              play_right,
  output logic [GAIN_W-1:0] gain,
  output logic              busy,
  output logic              overflow
);

  localparam logic [GAIN_W-1:0] GAIN_MAX = '1;
  localparam logic [GAIN_W-1:0] GAIN_ONE = GAIN_W'(1);
  localparam logic [GAIN_W-1:0] GAIN_TOP = GAIN_MAX - GAIN_ONE;
  localparam int CNT_W = (FADE_DIV > 1) ? $clog2(FADE_DIV) : 1;
  localparam logic [CNT_W-1:0] STEP_LAST = CNT_W'(FADE_DIV - 1);
  localparam int FCW = $clog2(CMD_DEPTH + 1);

  logic [1:0]       rst_sync;
  logic             rst_n;
  logic [2:0]       state;
  cmd_t             cur;
  cmd_t             head;
  logic [CNT_W-1:0] step_cnt;
  logic             step_done;
  logic             push;
  logic             pop;
  logic             full;
  logic             empty;
  logic [FCW-1:0]   fifo_count_unused;

  // Reset is asserted asynchronously but released on a clock edge.
  always_ff @(posedge clk_100 or negedge reset_n) begin
    if (!reset_n) rst_sync <= 2'b00;
    else          rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_n = rst_sync[1];

  assign push      = key_valid && key_is_cmd(key_code);
  assign pop       = (state == ST_IDLE) && sample_tick && !empty;
  assign step_done = (step_cnt == STEP_LAST);
  assign busy      = (state != ST_IDLE);

  cmd_fifo #(
    .DEPTH (CMD_DEPTH),
    .WIDTH ($bits(cmd_t))
  ) u_fifo (
    .clk   (clk_100),
    .rst_n (rst_n),
    .push  (push),
    .wdata (key_to_cmd(key_code)),
    .pop   (pop),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .count (fifo_count_unused)
  );

  // Sticky flag for a command lost on a full queue.
  always_ff @(posedge clk_100 or negedge rst_n) begin
    if (!rst_n)                       overflow <= 1'b0;
    else if (push && full && !pop)    overflow <= 1'b1;
  end

  // Sequencer FSM with its datapath: issue, fade, route swap.
  always_ff @(posedge clk_100 or negedge rst_n) begin
    if (!rst_n) begin
      state          <= ST_IDLE;
      cur            <= '0;
      step_cnt       <= '0;
      instruments    <= 4'd0;
      new_instrument <= 1'b0;
      next_delay     <= 1'b0;
      next_att       <= 1'b0;
      play_right     <= 1'b0;
      gain           <= GAIN_MAX;
    end else begin
      new_instrument <= 1'b0;
      next_delay     <= 1'b0;
      next_att       <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (pop) begin
            cur   <= head;
            state <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          step_cnt <= '0;
          case (cur.op)
            CMD_INSTR: begin
              instruments    <= cur.payload;
              new_instrument <= 1'b1;
              state          <= ST_IDLE;
            end
            CMD_DELAY: begin
              next_delay <= 1'b1;
              state      <= ST_IDLE;
            end
            CMD_ATT: begin
              next_att <= 1'b1;
              state    <= ST_IDLE;
            end
            default: state <= ST_FADE_OUT;
          endcase
        end
        ST_FADE_OUT: begin
          if (sample_tick) begin
            if (step_done) begin
              step_cnt <= '0;
              if (gain <= GAIN_ONE) begin
                gain  <= '0;
                state <= ST_SWAP;
              end else begin
                gain <= gain - GAIN_ONE;
              end
            end else begin
              step_cnt <= step_cnt + 1'b1;
            end
          end
        end
        ST_SWAP: begin
          play_right <= ~play_right;
          step_cnt   <= '0;
          state      <= ST_FADE_IN;
        end
        ST_FADE_IN: begin
          if (sample_tick) begin
            if (step_done) begin
              step_cnt <= '0;
              if (gain >= GAIN_TOP) begin
                gain  <= GAIN_MAX;
                state <= ST_IDLE;
              end else begin
                gain <= gain + GAIN_ONE;
              end
            end else begin
              step_cnt <= step_cnt + 1'b1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_synth_ctrl_sequencer.sv
// Directed bench for synth_ctrl_sequencer (CMD_DEPTH=4, GAIN_W=4, FADE_DIV=1).
module tb_synth_ctrl_sequencer;

  logic       clk_100 = 1'b0;
  logic       reset_n = 1'b0;
  logic       key_valid = 1'b0;
  logic [3:0] key_code = 4'd0;
  logic       sample_tick = 1'b0;
  logic [3:0] instruments;
  logic       new_instrument;
  logic       next_delay;
  logic       next_att;
  logic       play_right;
  logic [3:0] gain;
  logic       busy;
  logic       overflow;

  int n_tests = 0;
  int n_fail  = 0;

  synth_ctrl_sequencer #(
    .CMD_DEPTH (4),
    .GAIN_W    (4),
    .FADE_DIV  (1)
  ) dut (
    .clk_100        (clk_100),
    .reset_n        (reset_n),
    .key_valid      (key_valid),
    .key_code       (key_code),
    .sample_tick    (sample_tick),
    .instruments    (instruments),
    .new_instrument (new_instrument),
    .next_delay     (next_delay),
    .next_att       (next_att),
    .play_right     (play_right),
    .gain           (gain),
    .busy           (busy),
    .overflow       (overflow)
  );

  // Clock and reset
  always #5 clk_100 = ~clk_100;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs set before the call are sampled on this edge.
  task automatic cyc();
    @(posedge clk_100);
    #1;
  endtask

  task automatic key(input logic [3:0] c);
    key_valid = 1'b1;
    key_code  = c;
    cyc();
    key_valid = 1'b0;
  endtask

  // One sample tick; checks busy in the ISSUE slot, pulses and instrument
  // one cycle later, and that pulses are gone the cycle after.
  task automatic tick_expect(input string tag, input logic ni, input logic nd,
                             input logic na, input logic [3:0] instr);
    sample_tick = 1'b1;
    cyc();
    sample_tick = 1'b0;
    key_valid   = 1'b0;
    chk({tag, ".busy"}, busy, ni | nd | na);
    cyc();
    chk({tag, ".pulses"}, {new_instrument, next_delay, next_att}, {ni, nd, na});
    chk({tag, ".instr"}, instruments, instr);
    cyc();
    chk({tag, ".pulse_off"}, {new_instrument, next_delay, next_att}, 3'b000);
  endtask

  // Driver sequence and final report
  initial begin
    // Reset
    repeat (3) cyc();
    #2 reset_n = 1'b1;
    repeat (4) cyc();
    chk("rst.instr", instruments, 4'd0);
    chk("rst.gain", gain, 4'd15);
    chk("rst.play_right", play_right, 1'b0);
    chk("rst.busy", busy, 1'b0);
    chk("rst.overflow", overflow, 1'b0);
    chk("rst.pulses", {new_instrument, next_delay, next_att}, 3'b000);

    // Single instrument command: pulse lands one cycle after ISSUE
    key(4'd3);
    sample_tick = 1'b1;
    cyc();
    sample_tick = 1'b0;
    chk("t1.issue_busy", busy, 1'b1);
    chk("t1.issue_no_pulse", new_instrument, 1'b0);
    cyc();
    chk("t1.pulse", new_instrument, 1'b1);
    chk("t1.instr", instruments, 4'd3);
    chk("t1.busy_done", busy, 1'b0);
    cyc();
    chk("t1.pulse_off", new_instrument, 1'b0);
    chk("t1.gain", gain, 4'd15);
    chk("t1.play_right", play_right, 1'b0);

    // A, B, 5 queued back to back; drained one per tick, in order
    key(4'hA);
    key(4'hB);
    key(4'd5);
    tick_expect("t2.delay", 1'b0, 1'b1, 1'b0, 4'd3);
    repeat (7) cyc();
    tick_expect("t2.att", 1'b0, 1'b0, 1'b1, 4'd3);
    repeat (7) cyc();
    tick_expect("t2.instr", 1'b1, 1'b0, 1'b0, 4'd5);
    repeat (7) cyc();

    // Speaker swap: 15 ticks down, routing flip, 15 ticks up
    key(4'hF);
    sample_tick = 1'b1;
    cyc();
    sample_tick = 1'b0;
    cyc();
    cyc();
    chk("t3.start_busy", busy, 1'b1);
    chk("t3.start_gain", gain, 4'd15);
    for (int k = 1; k <= 40; k++) begin
      sample_tick = 1'b1;
      cyc();
      sample_tick = 1'b0;
      chk($sformatf("t3.gain%0d", k), gain,
          (k <= 15) ? 32'(15 - k) : (k <= 30) ? 32'(k - 15) : 32'd15);
      cyc();
      cyc();
      chk($sformatf("t3.route%0d", k), play_right, (k >= 15) ? 1'b1 : 1'b0);
      chk($sformatf("t3.busy%0d", k), busy, (k < 30) ? 1'b1 : 1'b0);
      chk($sformatf("t3.instr%0d", k), instruments, (k >= 31) ? 4'd2 : 4'd5);
      if (k == 5) key(4'd2);
    end

    // Overflow: fifth push dropped; push coincident with a pop is accepted
    key(4'd1);
    key(4'd2);
    key(4'd3);
    key(4'd4);
    chk("t4.no_ovf", overflow, 1'b0);
    key(4'd6);
    chk("t4.ovf", overflow, 1'b1);
    key_valid = 1'b1;
    key_code  = 4'd7;
    tick_expect("t4.d1", 1'b1, 1'b0, 1'b0, 4'd1);
    tick_expect("t4.d2", 1'b1, 1'b0, 1'b0, 4'd2);
    tick_expect("t4.d3", 1'b1, 1'b0, 1'b0, 4'd3);
    tick_expect("t4.d4", 1'b1, 1'b0, 1'b0, 4'd4);
    tick_expect("t4.d7", 1'b1, 1'b0, 1'b0, 4'd7);
    tick_expect("t4.empty", 1'b0, 1'b0, 1'b0, 4'd7);
    chk("t4.ovf_sticky", overflow, 1'b1);

    // Reset in the middle of a fade-out at gain 7 (routing currently right)
    key(4'hF);
    sample_tick = 1'b1;
    cyc();
    sample_tick = 1'b0;
    cyc();
    cyc();
    for (int k = 1; k <= 8; k++) begin
      sample_tick = 1'b1;
      cyc();
      sample_tick = 1'b0;
      cyc();
    end
    chk("t6.gain7", gain, 4'd7);
    chk("t6.pre_route", play_right, 1'b1);
    key(4'd4);
    #2 reset_n = 1'b0;
    #1;
    chk("t6.rst_gain", gain, 4'd15);
    chk("t6.rst_route", play_right, 1'b0);
    chk("t6.rst_busy", busy, 1'b0);
    chk("t6.rst_ovf", overflow, 1'b0);
    chk("t6.rst_instr", instruments, 4'd0);
    @(negedge clk_100);
    reset_n = 1'b1;
    repeat (4) cyc();
    tick_expect("t6.fifo_empty", 1'b0, 1'b0, 1'b0, 4'd0);

    // Ignored key codes
    key(4'd0);
    key(4'hC);
    key(4'hD);
    key(4'hE);
    tick_expect("t5.ignored", 1'b0, 1'b0, 1'b0, 4'd0);
    chk("t5.ovf", overflow, 1'b0);

    // Full queue with coincident push and pop: no overflow, nothing lost
    key(4'd1);
    key(4'd2);
    key(4'd3);
    key(4'd4);
    key_valid = 1'b1;
    key_code  = 4'd8;
    tick_expect("t7.d1", 1'b1, 1'b0, 1'b0, 4'd1);
    chk("t7.no_ovf", overflow, 1'b0);
    tick_expect("t7.d2", 1'b1, 1'b0, 1'b0, 4'd2);
    tick_expect("t7.d3", 1'b1, 1'b0, 1'b0, 4'd3);
    tick_expect("t7.d4", 1'b1, 1'b0, 1'b0, 4'd4);
    tick_expect("t7.d8", 1'b1, 1'b0, 1'b0, 4'd8);
    tick_expect("t7.empty", 1'b0, 1'b0, 1'b0, 4'd8);
    chk("t7.no_ovf_end", overflow, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
